spi_cmd_arbiter: RTL

- Shares the single SPI command consumer between `N_REQ` command producers.
- Each producer exposes a buffered command region (a word count plus random-access read). The arbiter selects one producer at a time, round-robin, and announces that producer's region to the consumer.
- It then routes the consumer's word reads to the owner and returns the owner's data. Ownership is released when the consumer signals completion.
- Sits between the command-generating blocks and the SPI bus front end.

---
 rtl/spi_cmd_arbiter_if.sv | 41 ++++
 rtl/spi_cmd_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter_if.sv
// Bus bundle between the SPI command producers, the arbiter and the SPI
// command consumer.
//   master : arbiter view (drives grant, producer read strobes, consumer data)
//   slave  : producer/consumer view
// Producer-side vectors are packed per producer i: [i*AW +: AW], [i*DW +: DW].
interface spi_cmd_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
);
  // producer side
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_region_end;
  logic [N_REQ-1:0]    req_r_en;
  logic [AW-1:0]       req_ptr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_done;
  logic [N_REQ-1:0]    req_ack;
  logic [N_REQ-1:0]    gnt;
  // consumer side
  logic                cons_send;
  logic [AW-1:0]       cons_region_end;
  logic                cons_r_en;
  logic [AW-1:0]       cons_ptr;
  logic [DW-1:0]       cons_data;
  logic                cons_done;
  logic                cmd_done;
  logic                err;

  modport master (
    input  req, req_region_end, req_data, req_done, cons_r_en, cons_ptr, cmd_done,
    output req_r_en, req_ptr, req_ack, gnt, cons_send, cons_region_end,
           cons_data, cons_done, err
  );

  modport slave (
    output req, req_region_end, req_data, req_done, cons_r_en, cons_ptr, cmd_done,
    input  req_r_en, req_ptr, req_ack, gnt, cons_send, cons_region_end,
           cons_data, cons_done, err
  );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI command consumer between N_REQ
// producers. The owner's region end is announced to the consumer, consumer
// word reads are forwarded to the owner, and ownership ends on cmd_done.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - spi_cmd_arbiter_if.master (producer and consumer signals)
// Optional: define SPI_ARB_WDOG_EN to build a watchdog that force-releases a
// grant after TIMEOUT cycles without progress and pulses err.
// All outputs are registered.
module spi_cmd_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned AW      = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  spi_cmd_arbiter_if.master bus
);
  localparam int unsigned LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SERVE, FETCH} state_t;

  state_t           state_q, state_n;
  logic [LW-1:0]    owner_q, owner_n;
  logic [LW-1:0]    last_q, last_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic [N_REQ-1:0] ack_q, ack_n;
  logic [N_REQ-1:0] ren_q, ren_n;
  logic [AW-1:0]    ptr_q, ptr_n;
  logic [AW-1:0]    rend_q, rend_n;
  logic [DW-1:0]    data_q, data_n;
  logic             send_q, send_n;
  logic             cdone_q, cdone_n;
  logic             rel;

  // per-producer views of the packed region-end and data buses
  logic [AW-1:0] rend_a [N_REQ];
  logic [DW-1:0] data_a [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_split
    assign rend_a[g] = bus.req_region_end[g*AW +: AW];
    assign data_a[g] = bus.req_data[g*DW +: DW];
  end

  // round-robin search starting one past the previous owner
  logic [LW-1:0] win, idx;
  logic          win_vld;
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = last_q;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = (idx == LW'(N_REQ - 1)) ? '0 : idx + LW'(1);
      if (!win_vld && bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

`ifdef SPI_ARB_WDOG_EN
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          err_q, err_n;
  logic          wdog_hit;
  assign wdog_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

  // next-state and next-output logic
  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    last_n  = last_q;
    gnt_n   = gnt_q;
    ack_n   = '0;
    ren_n   = ren_q;
    ptr_n   = ptr_q;
    rend_n  = rend_q;
    data_n  = data_q;
    send_n  = 1'b0;
    cdone_n = 1'b0;
    rel     = 1'b0;
`ifdef SPI_ARB_WDOG_EN
    cnt_n   = cnt_q;
    err_n   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_n = SERVE;
          owner_n = win;
          gnt_n   = N_REQ'(1) << win;
          rend_n  = rend_a[win];
          send_n  = 1'b1;
`ifdef SPI_ARB_WDOG_EN
          cnt_n   = '0;
`endif
        end
      end
      SERVE: begin
`ifdef SPI_ARB_WDOG_EN
        cnt_n = cnt_q + CW'(1);
`endif
        if (bus.cmd_done) begin
          rel = 1'b1;
        end
`ifdef SPI_ARB_WDOG_EN
        else if (wdog_hit) begin
          rel   = 1'b1;
          err_n = 1'b1;
        end
`endif
        // cons_done high means the consumer's request was just answered
        else if (bus.cons_r_en && !cdone_q) begin
          ren_n   = gnt_q;
          ptr_n   = bus.cons_ptr;
          state_n = FETCH;
        end
      end
      FETCH: begin
`ifdef SPI_ARB_WDOG_EN
        cnt_n = cnt_q + CW'(1);
`endif
        // cmd_done here abandons the read; no cons_done is issued
        if (bus.cmd_done) begin
          rel = 1'b1;
        end
`ifdef SPI_ARB_WDOG_EN
        else if (wdog_hit) begin
          rel   = 1'b1;
          err_n = 1'b1;
        end
`endif
        else if (bus.req_done[owner_q]) begin
          data_n  = data_a[owner_q];
          cdone_n = 1'b1;
          ren_n   = '0;
          state_n = SERVE;
`ifdef SPI_ARB_WDOG_EN
          cnt_n   = '0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    // release of the current owner
    if (rel) begin
      ack_n   = gnt_q;
      gnt_n   = '0;
      last_n  = owner_q;
      ren_n   = '0;
      state_n = IDLE;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LW'(N_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      ren_q   <= '0;
      ptr_q   <= '0;
      rend_q  <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      gnt_q   <= gnt_n;
      ack_q   <= ack_n;
      ren_q   <= ren_n;
      ptr_q   <= ptr_n;
      rend_q  <= rend_n;
      data_q  <= data_n;
      send_q  <= send_n;
      cdone_q <= cdone_n;
    end
  end

`ifdef SPI_ARB_WDOG_EN
  // watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      err_q <= err_n;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gnt             = gnt_q;
  assign bus.req_ack         = ack_q;
  assign bus.req_r_en        = ren_q;
  assign bus.req_ptr         = ptr_q;
  assign bus.cons_send       = send_q;
  assign bus.cons_region_end = rend_q;
  assign bus.cons_data       = data_q;
  assign bus.cons_done       = cdone_q;
endmodule
